// File: rtl/maze_tile_renderer_if.sv
// Bus bundle for maze_tile_renderer: control handshake, map-row write
// channel and pixel outputs. The optional collision query port exists
// only when WALL_QUERY_EN is defined.
interface maze_tile_renderer_if #(
    parameter int MAP_COLS = 96,
    parameter int MAP_ROWS = 100
);
    logic                        start;
    logic                        ack;
    logic [9:0]                  hCount;
    logic [9:0]                  vCount;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [$clog2(MAP_ROWS)-1:0] wr_row;
    logic [MAP_COLS-1:0]         wr_data;
    logic                        wr_err;
    logic                        busy;
    logic                        active;
    logic                        wallFill;
    logic [11:0]                 rgb;
`ifdef WALL_QUERY_EN
    logic [$clog2(MAP_COLS)-1:0] query_col;
    logic [$clog2(MAP_ROWS)-1:0] query_row;
    logic                        query_hit;
`endif

    modport master (
        output start, ack, hCount, vCount, wr_valid, wr_row, wr_data,
`ifdef WALL_QUERY_EN
        output query_col, query_row,
        input  query_hit,
`endif
        input  wr_ready, wr_err, busy, active, wallFill, rgb
    );

    modport slave (
        input  start, ack, hCount, vCount, wr_valid, wr_row, wr_data,
`ifdef WALL_QUERY_EN
        input  query_col, query_row,
        output query_hit,
`endif
        output wr_ready, wr_err, busy, active, wallFill, rgb
    );
endinterface

// File: rtl/maze_tile_renderer.sv
// maze_tile_renderer: runtime-loadable tile-bitmap maze renderer.
// After reset the map is wiped one row per cycle (CLEAR), then rows can be
// loaded in IDLE and wall pixels are produced in ACTIVE through a 2-stage
// pipeline (hCount/vCount -> wallFill/rgb in exactly 2 clocks).
// Optional feature macro: WALL_QUERY_EN adds a registered collision query
// port backed by a second map read port; out-of-range queries report a wall.
module maze_tile_renderer #(
    parameter int          OFFSET_H   = 130,
    parameter int          OFFSET_V   = 24,
    parameter int          TILE_SHIFT = 2,
    parameter int          MAP_COLS   = 96,
    parameter int          MAP_ROWS   = 100,
    parameter logic [11:0] WALL_COLOR = 12'h00F,
    parameter logic [11:0] BG_COLOR   = 12'h000
) (
    input logic                   clk,
    input logic                   reset,
    maze_tile_renderer_if.slave   bus
);
    localparam int ROW_W = $clog2(MAP_ROWS);
    localparam int COL_W = $clog2(MAP_COLS);
    localparam logic signed [10:0] OFF_H  = 11'(OFFSET_H);
    localparam logic signed [10:0] OFF_V  = 11'(OFFSET_V);
    localparam logic signed [10:0] SPAN_H = 11'(MAP_COLS << TILE_SHIFT);
    localparam logic signed [10:0] SPAN_V = 11'(MAP_ROWS << TILE_SHIFT);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ROW_W-1:0]    r_clr_cnt;
    logic                r_wr_err;
    logic                r_wr_ready;
    logic                r_busy;
    logic                r_active;
    logic [MAP_COLS-1:0] r_map [MAP_ROWS];

    logic                w_we;
    logic [ROW_W-1:0]    w_waddr;
    logic [MAP_COLS-1:0] w_wdata;
    logic                w_bad_wr;

    // Pixel pipeline signals; the 11-bit signed offsets keep pixels left of
    // or above the map negative instead of wrapping into range.
    logic signed [10:0]  w_dh;
    logic signed [10:0]  w_dv;
    logic                w_in_h;
    logic                w_in_v;
    logic [COL_W-1:0]    w_col;
    logic [ROW_W-1:0]    w_row;
    logic                r_s1_inside;
    logic                r_s1_active;
    logic [COL_W-1:0]    r_s1_col;
    logic [MAP_COLS-1:0] r_s1_word;
    logic                w_fill_next;
    logic                r_wall_fill;
    logic [11:0]         r_rgb;

    assign w_dh   = signed'({1'b0, bus.hCount}) - OFF_H;
    assign w_dv   = signed'({1'b0, bus.vCount}) - OFF_V;
    assign w_in_h = (w_dh >= 11'sd0) && (w_dh < SPAN_H);
    assign w_in_v = (w_dv >= 11'sd0) && (w_dv < SPAN_V);
    assign w_col  = w_in_h ? w_dh[TILE_SHIFT +: COL_W] : {COL_W{1'b0}};
    assign w_row  = w_in_v ? w_dv[TILE_SHIFT +: ROW_W] : {ROW_W{1'b0}};
    assign w_fill_next = r_s1_inside & r_s1_word[r_s1_col] & r_s1_active;

    assign bus.wr_ready = r_wr_ready;
    assign bus.wr_err   = r_wr_err;
    assign bus.busy     = r_busy;
    assign bus.active   = r_active;
    assign bus.wallFill = r_wall_fill;
    assign bus.rgb      = r_rgb;

    // Next-state: CLEAR sweeps every row once, ack beats start in ACTIVE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == ROW_W'(MAP_ROWS - 1)) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.ack) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_ACTIVE;
                end
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    // Map write port select: clear sweep in CLEAR, accepted loads in IDLE.
    always_comb begin
        w_we     = 1'b0;
        w_waddr  = {ROW_W{1'b0}};
        w_wdata  = {MAP_COLS{1'b0}};
        w_bad_wr = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_cnt;
            end
            ST_IDLE: begin
                if (bus.wr_valid) begin
                    if ({1'b0, bus.wr_row} < (ROW_W + 1)'(MAP_ROWS)) begin
                        w_we    = 1'b1;
                        w_waddr = bus.wr_row;
                        w_wdata = bus.wr_data;
                    end else begin
                        w_bad_wr = 1'b1;
                    end
                end else begin
                    w_we = 1'b0;
                end
            end
            default: w_we = 1'b0;
        endcase
    end

    // Control registers; status outputs are decoded from the next state so
    // they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= {ROW_W{1'b0}};
            r_wr_err   <= 1'b0;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_active   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + ROW_W'(1) : {ROW_W{1'b0}};
            if ((r_state == ST_IDLE) && (w_state_next == ST_ACTIVE)) begin
                r_wr_err <= 1'b0;
            end else if (w_bad_wr) begin
                r_wr_err <= 1'b1;
            end
            r_wr_ready <= (w_state_next == ST_IDLE);
            r_busy     <= (w_state_next == ST_CLEAR);
            r_active   <= (w_state_next == ST_ACTIVE);
        end
    end

    // Map storage write port; contents are rebuilt by CLEAR after reset.
    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            r_map[w_waddr] <= w_wdata;
        end
    end

    // Pixel pipeline: stage 1 fetches the row word, stage 2 picks the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_inside <= 1'b0;
            r_s1_active <= 1'b0;
            r_s1_col    <= {COL_W{1'b0}};
            r_s1_word   <= {MAP_COLS{1'b0}};
            r_wall_fill <= 1'b0;
            r_rgb       <= BG_COLOR;
        end else begin
            r_s1_inside <= w_in_h & w_in_v;
            r_s1_active <= (r_state == ST_ACTIVE);
            r_s1_col    <= w_col;
            r_s1_word   <= r_map[w_row];
            r_wall_fill <= w_fill_next;
            r_rgb       <= w_fill_next ? WALL_COLOR : BG_COLOR;
        end
    end

`ifdef WALL_QUERY_EN
    logic             w_q_oob;
    logic [ROW_W-1:0] w_q_row;
    logic [COL_W-1:0] w_q_col;
    logic             r_query_hit;

    assign w_q_oob = ({1'b0, bus.query_row} >= (ROW_W + 1)'(MAP_ROWS)) ||
                     ({1'b0, bus.query_col} >= (COL_W + 1)'(MAP_COLS));
    assign w_q_row = w_q_oob ? {ROW_W{1'b0}} : bus.query_row;
    assign w_q_col = w_q_oob ? {COL_W{1'b0}} : bus.query_col;
    assign bus.query_hit = r_query_hit;

    // Collision query read port; anything off the map counts as wall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_query_hit <= 1'b0;
        end else begin
            r_query_hit <= w_q_oob | r_map[w_q_row][w_q_col];
        end
    end
`endif
endmodule

// File: tb/tb_maze_tile_renderer.sv
// Self-checking bench for maze_tile_renderer against a behavioural map model.
module tb_maze_tile_renderer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit [95:0] model_map [100];

    maze_tile_renderer_if bus_if ();
    maze_tile_renderer dut (.clk(clk), .reset(reset), .bus(bus_if.slave));

    always #5 clk = ~clk;

    // Expected wall bit for a screen pixel, straight from the tile geometry.
    function automatic bit exp_wall(input int h, input int v);
        int dh = h - 130;
        int dv = v - 24;
        if (dh < 0 || dh >= 384 || dv < 0 || dv >= 400) return 1'b0;
        return model_map[dv / 4][dh / 4];
    endfunction

    task automatic clear_model();
        for (int r = 0; r < 100; r++) model_map[r] = '0;
    endtask

    task automatic pix(input int h, input int v, output logic wf, output logic [11:0] c);
        @(negedge clk);
        bus_if.hCount = 10'(h);
        bus_if.vCount = 10'(v);
        repeat (2) @(negedge clk);
        wf = bus_if.wallFill;
        c  = bus_if.rgb;
    endtask

    task automatic write_row(input int row, input bit [95:0] data);
        @(negedge clk);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_row   = 7'(row);
        bus_if.wr_data  = data;
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        if (row < 100) model_map[row] = data;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        total++;
        if (bus_if.active !== 1'b1) begin
            bad++;
            $display("FAIL start_active: got %b want 1", bus_if.active);
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
    endtask

    // Wait for CLEAR to finish, returning how many sampled cycles busy was high.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus_if.busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // Random pixel stream in ACTIVE; checks every output 2 cycles later.
    task automatic scan(input int n);
        bit q[$];
        bit e;
        int h, v;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = q.pop_front();
                total++;
                if (bus_if.wallFill !== e) begin
                    bad++;
                    $display("FAIL scan_wall: got %b want %b (step %0d)", bus_if.wallFill, e, i);
                end
                total++;
                if (bus_if.rgb !== (e ? 12'h00F : 12'h000)) begin
                    bad++;
                    $display("FAIL scan_rgb: got %h want %h", bus_if.rgb, e ? 12'h00F : 12'h000);
                end
            end
            if (i < n) begin
                h = $urandom_range(120, 520);
                v = $urandom_range(14, 430);
                bus_if.hCount = 10'(h);
                bus_if.vCount = 10'(v);
                q.push_back(exp_wall(h, v));
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus_if.busy, bus_if.active, bus_if.wr_ready, bus_if.wr_err, bus_if.wallFill} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 10000",
                     {bus_if.busy, bus_if.active, bus_if.wr_ready, bus_if.wr_err, bus_if.wallFill});
        end
        total++;
        if (bus_if.rgb !== 12'h000) begin
            bad++;
            $display("FAIL reset_rgb: got %h want 000", bus_if.rgb);
        end
        reset = 1'b0;
        clear_model();
        count_busy(cnt);
        total++;
        if (cnt != 100) begin
            bad++;
            $display("FAIL clear_len: got %0d want 100", cnt);
        end
        total++;
        if (bus_if.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready: got %b want 1", bus_if.wr_ready);
        end
        do_start();
        scan(150);
        do_ack();
    endtask

    task automatic test_pixel_edges();
        logic wf;
        logic [11:0] c;
        int hs[5] = '{130, 133, 134, 129, 514};
        int vs[5] = '{24, 27, 24, 24, 24};
        write_row(0, 96'h1);
        // ack while idle must not disturb anything
        @(negedge clk);
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
        total++;
        if (bus_if.active !== 1'b0 || bus_if.wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ack: active=%b ready=%b want 0 1", bus_if.active, bus_if.wr_ready);
        end
        do_start();
        for (int k = 0; k < 5; k++) begin
            pix(hs[k], vs[k], wf, c);
            total++;
            if (wf !== exp_wall(hs[k], vs[k]) || c !== (exp_wall(hs[k], vs[k]) ? 12'h00F : 12'h000)) begin
                bad++;
                $display("FAIL edge_pix(%0d,%0d): got %b/%h want %b", hs[k], vs[k], wf, c, exp_wall(hs[k], vs[k]));
            end
        end
    endtask

    task automatic test_stall_and_ack();
        logic wf;
        logic [11:0] c;
        @(negedge clk);
        bus_if.wr_valid = 1'b1;
        bus_if.wr_row   = 7'd0;
        bus_if.wr_data  = '1;
        @(negedge clk);
        total++;
        if (bus_if.wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL active_ready: got %b want 0", bus_if.wr_ready);
        end
        @(negedge clk);
        bus_if.wr_valid = 1'b0;
        pix(134, 24, wf, c);
        total++;
        if (wf !== 1'b0) begin
            bad++;
            $display("FAIL stall_nowrite: got %b want 0", wf);
        end
        pix(130, 24, wf, c);
        bus_if.ack   = 1'b1;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.ack   = 1'b0;
        bus_if.start = 1'b0;
        total++;
        if (bus_if.active !== 1'b0) begin
            bad++;
            $display("FAIL ack_wins: active got %b want 0", bus_if.active);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (bus_if.wallFill !== 1'b0 || bus_if.rgb !== 12'h000) begin
                bad++;
                $display("FAIL post_ack_fill: got %b/%h want 0/000", bus_if.wallFill, bus_if.rgb);
            end
        end
    endtask

    task automatic test_wr_err();
        write_row(100, '1);
        total++;
        if (bus_if.wr_err !== 1'b1) begin
            bad++;
            $display("FAIL wr_err_set: got %b want 1", bus_if.wr_err);
        end
        write_row(127, '1);
        do_start();
        total++;
        if (bus_if.wr_err !== 1'b0) begin
            bad++;
            $display("FAIL wr_err_clr: got %b want 0", bus_if.wr_err);
        end
        scan(100);
        do_ack();
    endtask

    task automatic test_back_to_back();
        int r;
        bit [95:0] d;
        @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 99);
            d = {$urandom, $urandom, $urandom};
            bus_if.wr_valid = 1'b1;
            bus_if.wr_row   = 7'(r);
            bus_if.wr_data  = d;
            model_map[r]    = d;
            @(negedge clk);
        end
        bus_if.wr_valid = 1'b0;
        do_start();
        scan(400);
        do_ack();
    endtask

    task automatic test_reset_mid();
        logic wf;
        logic [11:0] c;
        int cnt;
        write_row(5, '1);
        do_start();
        pix(130, 44, wf, c);
        total++;
        if (wf !== 1'b1 || c !== 12'h00F) begin
            bad++;
            $display("FAIL row5_wall: got %b/%h want 1/00F", wf, c);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus_if.wallFill !== 1'b0 || bus_if.busy !== 1'b1 || bus_if.active !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: fill=%b busy=%b active=%b want 0 1 0",
                     bus_if.wallFill, bus_if.busy, bus_if.active);
        end
        reset = 1'b0;
        clear_model();
        count_busy(cnt);
        total++;
        if (cnt != 100) begin
            bad++;
            $display("FAIL reclear_len: got %0d want 100", cnt);
        end
        do_start();
        pix(130, 44, wf, c);
        total++;
        if (wf !== 1'b0) begin
            bad++;
            $display("FAIL reclear_pix: got %b want 0", wf);
        end
        scan(100);
        do_ack();
    endtask

`ifdef WALL_QUERY_EN
    task automatic test_query();
        int qc[4] = '{7, 8, 96, 0};
        int qr[4] = '{3, 3, 0, 100};
        bit e;
        write_row(3, 96'h80);
        for (int k = 0; k < 40; k++) begin
            if (k >= 4) begin
                qc[0] = $urandom_range(0, 100);
                qr[0] = $urandom_range(0, 104);
            end
            @(negedge clk);
            bus_if.query_col = 7'(qc[k < 4 ? k : 0]);
            bus_if.query_row = 7'(qr[k < 4 ? k : 0]);
            e = (qc[k < 4 ? k : 0] >= 96 || qr[k < 4 ? k : 0] >= 100) ? 1'b1
                : model_map[qr[k < 4 ? k : 0]][qc[k < 4 ? k : 0]];
            @(negedge clk);
            total++;
            if (bus_if.query_hit !== e) begin
                bad++;
                $display("FAIL query(%0d,%0d): got %b want %b", bus_if.query_col, bus_if.query_row,
                         bus_if.query_hit, e);
            end
        end
    endtask
`endif

    initial begin
        bus_if.start    = 1'b0;
        bus_if.ack      = 1'b0;
        bus_if.hCount   = 10'd0;
        bus_if.vCount   = 10'd0;
        bus_if.wr_valid = 1'b0;
        bus_if.wr_row   = 7'd0;
        bus_if.wr_data  = '0;
`ifdef WALL_QUERY_EN
        bus_if.query_col = 7'd0;
        bus_if.query_row = 7'd0;
`endif
        test_reset();
        test_pixel_edges();
        test_stall_and_ack();
        test_wr_err();
        test_back_to_back();
        test_reset_mid();
`ifdef WALL_QUERY_EN
        test_query();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
